// File: rtl/matmul_pkg.sv
// Shared opcode/funct3 codes, FSM state type and defaults for the matmul PCPI sequencer.
package matmul_pkg;

  localparam int DEF_N      = 3;
  localparam int DEF_DATA_W = 16;
  localparam int DEF_ACC_W  = 32;
  localparam int STEPS      = 3 * DEF_N - 2;

  localparam logic [6:0] CUSTOM0 = 7'b0001011;

  localparam logic [2:0] F3_LOAD   = 3'b000;
  localparam logic [2:0] F3_SETTHR = 3'b001;
  localparam logic [2:0] F3_READ   = 3'b010;
  localparam logic [2:0] F3_CLEAR  = 3'b101;
  localparam logic [2:0] F3_START  = 3'b111;

  // Operand store holds A, B and bias blocks of 9 words each.
  localparam logic [4:0] OP_ADDR_LIMIT = 5'd27;

  localparam logic signed [31:0] THR_RESET = -32'sd70;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_RUN   = 3'd2,
    S_LATCH = 3'd3,
    S_READ  = 3'd4,
    S_RESP  = 3'd5,
    S_HOLD  = 3'd6
  } state_e;

  function automatic int steps_of(input int n);
    return 3 * n - 2;
  endfunction

endpackage

// File: rtl/matmul_insn_decode.sv
// Combinational custom-0 instruction decoder; SETTHR is claimed only when
// MATMUL_THRESHOLD_EN is defined.
module matmul_insn_decode
  import matmul_pkg::*;
(
  input  logic [31:0] insn_i,
  output logic        claim_o,
  output logic [2:0]  cmd_o,
  output logic [4:0]  addr_o,
  output logic [15:0] value_o
);

  logic [6:0] opcode_s;
  logic [2:0] funct3_s;
  logic       known_s;
  logic       unused_insn_bit_s;

  assign opcode_s          = insn_i[6:0];
  assign funct3_s          = insn_i[14:12];
  assign unused_insn_bit_s = insn_i[31];

  // Set of funct3 codes implemented by this build.
  always_comb begin
    known_s = 1'b0;
    case (funct3_s)
      F3_LOAD, F3_READ, F3_CLEAR, F3_START: known_s = 1'b1;
`ifdef MATMUL_THRESHOLD_EN
      F3_SETTHR: known_s = 1'b1;
`endif
      default: known_s = 1'b0;
    endcase
  end

  assign claim_o = (opcode_s == CUSTOM0) && known_s;
  assign cmd_o   = funct3_s;
  assign addr_o  = insn_i[11:7];
  assign value_o = insn_i[30:15];

endmodule

// File: rtl/matmul_seq_ctrl.sv
// PCPI sequencer for an NxN systolic matmul: operand load, run/latch, result read.
// Optional signed threshold compare on READ is enabled by defining MATMUL_THRESHOLD_EN.
module matmul_seq_ctrl
  import matmul_pkg::*;
#(
  parameter int N      = DEF_N,
  parameter int DATA_W = DEF_DATA_W,
  parameter int ACC_W  = DEF_ACC_W
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              pcpi_valid,
  input  logic [31:0]       pcpi_insn,
  output logic              pcpi_wr,
  output logic [31:0]       pcpi_rd,
  output logic              pcpi_wait,
  output logic              pcpi_ready,
  output logic              op_we,
  output logic [4:0]        op_addr,
  output logic [DATA_W-1:0] op_wdata,
  output logic              arr_en,
  output logic              arr_first,
  output logic [2:0]        arr_step,
  output logic              res_capture,
  output logic [3:0]        res_rd_addr,
  input  logic [ACC_W-1:0]  res_rd_data
);

  localparam logic [7:0]  STEP_MAX = 8'(3 * N - 3);
  localparam logic [31:0] STEPS_RD = 32'(steps_of(N));
  localparam logic [4:0]  NN       = 5'(N * N);

  logic        dec_claim_s;
  logic [2:0]  dec_cmd_s;
  logic [4:0]  dec_addr_s;
  logic [15:0] dec_value_s;
  logic        accept_s;

  state_e      state_q, state_d;
  logic [7:0]  step_q, step_d;
  logic [2:0]  cmd_q, cmd_d;
  logic [4:0]  addr_q, addr_d;
  logic [15:0] value_q, value_d;
  logic        aborted_q, aborted_d;

  logic              ready_q, ready_d;
  logic              wr_q, wr_d;
  logic [31:0]       rd_q, rd_d;
  logic              wait_q, wait_d;
  logic              op_we_q, op_we_d;
  logic [4:0]        op_addr_q, op_addr_d;
  logic [DATA_W-1:0] op_wdata_q, op_wdata_d;
  logic              arr_en_q, arr_en_d;
  logic              arr_first_q, arr_first_d;
  logic [2:0]        arr_step_q, arr_step_d;
  logic              cap_q, cap_d;
  logic [3:0]        rd_addr_q, rd_addr_d;

  logic [31:0] raw32_s;
  logic [31:0] read_val_s;

  matmul_insn_decode u_decode (
    .insn_i  (pcpi_insn),
    .claim_o (dec_claim_s),
    .cmd_o   (dec_cmd_s),
    .addr_o  (dec_addr_s),
    .value_o (dec_value_s)
  );

  assign accept_s = (state_q == S_IDLE) && pcpi_valid && dec_claim_s;
  assign raw32_s  = 32'($signed(res_rd_data));

`ifdef MATMUL_THRESHOLD_EN
  logic signed [31:0] thr_q, thr_d;
  assign read_val_s = (addr_q >= NN) ? 32'd0 : {31'd0, ($signed(raw32_s) >= thr_q)};
`else
  assign read_val_s = (addr_q >= NN) ? 32'd0 : raw32_s;
`endif

  // State, command context and threshold registers.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q   <= S_IDLE;
      step_q    <= 8'd0;
      cmd_q     <= 3'd0;
      addr_q    <= 5'd0;
      value_q   <= 16'd0;
      aborted_q <= 1'b0;
`ifdef MATMUL_THRESHOLD_EN
      thr_q     <= THR_RESET;
`endif
    end else begin
      state_q   <= state_d;
      step_q    <= step_d;
      cmd_q     <= cmd_d;
      addr_q    <= addr_d;
      value_q   <= value_d;
      aborted_q <= aborted_d;
`ifdef MATMUL_THRESHOLD_EN
      thr_q     <= thr_d;
`endif
    end
  end

  // Next-state and command-context logic.
  always_comb begin
    state_d   = state_q;
    step_d    = step_q;
    cmd_d     = cmd_q;
    addr_d    = addr_q;
    value_d   = value_q;
    aborted_d = aborted_q;
`ifdef MATMUL_THRESHOLD_EN
    thr_d     = thr_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (accept_s) begin
          cmd_d     = dec_cmd_s;
          addr_d    = dec_addr_s;
          value_d   = dec_value_s;
          step_d    = 8'd0;
          aborted_d = 1'b0;
`ifdef MATMUL_THRESHOLD_EN
          if (dec_cmd_s == F3_SETTHR) begin
            thr_d = 32'($signed(dec_value_s));
          end else begin
            thr_d = thr_q;
          end
`endif
          case (dec_cmd_s)
            F3_START: state_d = S_RUN;
            F3_READ:  state_d = S_READ;
            default:  state_d = S_LOAD;
          endcase
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RUN: begin
        if (!pcpi_valid) begin
          aborted_d = 1'b1;
        end else begin
          aborted_d = aborted_q;
        end
        if (step_q >= STEP_MAX) begin
          state_d = S_LATCH;
        end else begin
          step_d = step_q + 8'd1;
        end
      end
      S_LATCH: begin
        step_d = 8'd0;
        // A requester that gave up mid-sequence still gets its results latched.
        if (aborted_q || !pcpi_valid) begin
          state_d = S_HOLD;
        end else begin
          state_d = S_RESP;
        end
      end
      S_READ:  state_d = S_RESP;
      S_LOAD:  state_d = S_HOLD;
      S_RESP:  state_d = S_HOLD;
      S_HOLD:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output values for the upcoming state, registered below.
  always_comb begin
    ready_d     = 1'b0;
    wr_d        = 1'b0;
    rd_d        = 32'd0;
    wait_d      = 1'b0;
    op_we_d     = 1'b0;
    op_addr_d   = 5'd0;
    op_wdata_d  = '0;
    arr_en_d    = 1'b0;
    arr_first_d = 1'b0;
    arr_step_d  = 3'd0;
    cap_d       = 1'b0;
    rd_addr_d   = rd_addr_q;
    case (state_d)
      S_LOAD: begin
        ready_d = 1'b1;
        wr_d    = 1'b1;
        if ((cmd_d == F3_LOAD) && (addr_d < OP_ADDR_LIMIT)) begin
          op_we_d    = 1'b1;
          op_addr_d  = addr_d;
          op_wdata_d = DATA_W'(value_d);
        end else begin
          op_we_d = 1'b0;
        end
      end
      S_RUN: begin
        wait_d      = 1'b1;
        arr_en_d    = 1'b1;
        arr_step_d  = step_d[2:0];
        arr_first_d = (step_d == 8'd0);
      end
      S_LATCH: begin
        wait_d = 1'b1;
        cap_d  = 1'b1;
      end
      S_READ: rd_addr_d = addr_d[3:0];
      S_RESP: begin
        ready_d = 1'b1;
        wr_d    = 1'b1;
        if (cmd_d == F3_START) begin
          rd_d = STEPS_RD;
        end else begin
          rd_d = read_val_s;
        end
      end
      default: begin
        ready_d = 1'b0;
      end
    endcase
  end

  // Registered outputs.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      ready_q     <= 1'b0;
      wr_q        <= 1'b0;
      rd_q        <= 32'd0;
      wait_q      <= 1'b0;
      op_we_q     <= 1'b0;
      op_addr_q   <= 5'd0;
      op_wdata_q  <= '0;
      arr_en_q    <= 1'b0;
      arr_first_q <= 1'b0;
      arr_step_q  <= 3'd0;
      cap_q       <= 1'b0;
      rd_addr_q   <= 4'd0;
    end else begin
      ready_q     <= ready_d;
      wr_q        <= wr_d;
      rd_q        <= rd_d;
      wait_q      <= wait_d;
      op_we_q     <= op_we_d;
      op_addr_q   <= op_addr_d;
      op_wdata_q  <= op_wdata_d;
      arr_en_q    <= arr_en_d;
      arr_first_q <= arr_first_d;
      arr_step_q  <= arr_step_d;
      cap_q       <= cap_d;
      rd_addr_q   <= rd_addr_d;
    end
  end

  assign pcpi_ready  = ready_q;
  assign pcpi_wr     = wr_q;
  assign pcpi_rd     = rd_q;
  assign pcpi_wait   = wait_q;
  assign op_we       = op_we_q;
  assign op_addr     = op_addr_q;
  assign op_wdata    = op_wdata_q;
  assign arr_en      = arr_en_q;
  assign arr_first   = arr_first_q;
  assign arr_step    = arr_step_q;
  assign res_capture = cap_q;
  assign res_rd_addr = rd_addr_q;

endmodule

// File: tb/tb_matmul_seq_ctrl.sv
// Scoreboard bench for matmul_seq_ctrl: responses are queued at issue time and
// popped by a monitor whenever pcpi_ready is seen.
`timescale 1ns/1ps
module tb_matmul_seq_ctrl;

  localparam int N      = 3;
  localparam int DATA_W = 16;
  localparam int ACC_W  = 32;

  logic              clk = 1'b0;
  logic              resetn = 1'b0;
  logic              pcpi_valid = 1'b0;
  logic [31:0]       pcpi_insn = 32'd0;
  logic              pcpi_wr, pcpi_wait, pcpi_ready;
  logic [31:0]       pcpi_rd;
  logic              op_we, arr_en, arr_first, res_capture;
  logic [4:0]        op_addr;
  logic [DATA_W-1:0] op_wdata;
  logic [2:0]        arr_step;
  logic [3:0]        res_rd_addr;
  logic [ACC_W-1:0]  res_rd_data;
  logic [ACC_W-1:0]  bank [0:15];

  int          vectors = 0;
  int          miscompares = 0;
  logic [31:0] sb [$];
  logic [31:0] mon_exp;
  bit          mon_en = 1'b0;
`ifdef MATMUL_THRESHOLD_EN
  logic signed [31:0] thr_m = -32'sd70;
`endif

  assign res_rd_data = bank[res_rd_addr];

  always #5 clk = ~clk;

  matmul_seq_ctrl #(.N(N), .DATA_W(DATA_W), .ACC_W(ACC_W)) dut (
    .clk(clk), .resetn(resetn),
    .pcpi_valid(pcpi_valid), .pcpi_insn(pcpi_insn),
    .pcpi_wr(pcpi_wr), .pcpi_rd(pcpi_rd), .pcpi_wait(pcpi_wait), .pcpi_ready(pcpi_ready),
    .op_we(op_we), .op_addr(op_addr), .op_wdata(op_wdata),
    .arr_en(arr_en), .arr_first(arr_first), .arr_step(arr_step),
    .res_capture(res_capture), .res_rd_addr(res_rd_addr), .res_rd_data(res_rd_data)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] mk(input logic [2:0] f3, input logic [4:0] a, input logic [15:0] v);
    return {1'b0, v, f3, a, 7'b0001011};
  endfunction

  function automatic logic [31:0] run_word(input logic en, input logic first, input logic wt,
                                           input logic cap, input logic [2:0] st);
    return {24'd0, en, first, wt, cap, 1'b0, st};
  endfunction

  function automatic logic [31:0] read_model(input logic [4:0] a);
    logic [31:0] v;
    v = bank[a[3:0]];
    if (a >= 5'd9) return 32'd0;
`ifdef MATMUL_THRESHOLD_EN
    return ($signed(v) >= thr_m) ? 32'd1 : 32'd0;
`else
    return v;
`endif
  endfunction

  // Response monitor: every ready pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    if (mon_en) begin
      if (pcpi_ready) begin
        if (sb.size() == 0) begin
          check_val("unexpected_ready", {31'd0, pcpi_ready}, 32'd0);
        end else begin
          mon_exp = sb.pop_front();
          check_val("resp_rd", pcpi_rd, mon_exp);
          check_val("resp_wr", {31'd0, pcpi_wr}, 32'd1);
        end
      end else begin
        check_val("idle_rd_wr", pcpi_rd | {31'd0, pcpi_wr}, 32'd0);
      end
    end
  end

  // Drives the instruction early in cycle T and returns at cycle T's negedge.
  task automatic issue(input logic [31:0] insn);
    @(posedge clk); #1;
    pcpi_valid = 1'b1;
    pcpi_insn  = insn;
    @(negedge clk);
  endtask

  task automatic drop_valid();
    @(posedge clk); #1;
    pcpi_valid = 1'b0;
  endtask

  task automatic finish_cmd();
    @(negedge clk);
    @(negedge clk);
    check_val("sb_drain", sb.size(), 32'd0);
  endtask

  // LOAD / CLEAR / SETTHR: response and any store write in T+1.
  task automatic do_imm(input logic [2:0] f3, input logic [4:0] a, input logic [15:0] v, input bit hold);
    logic we_exp;
    we_exp = (f3 == 3'b000) && (a < 5'd27);
    sb.push_back(32'd0);
    issue(mk(f3, a, v));
    check_val("imm_we_T", {31'd0, op_we}, 32'd0);
    @(negedge clk);
    check_val("imm_ready", {31'd0, pcpi_ready}, 32'd1);
    check_val("imm_we", {31'd0, op_we}, {31'd0, we_exp});
    check_val("imm_addr", {27'd0, op_addr}, we_exp ? {27'd0, a} : 32'd0);
    check_val("imm_wdata", {16'd0, op_wdata}, we_exp ? {16'd0, v} : 32'd0);
    check_val("imm_arr", {31'd0, arr_en}, 32'd0);
    if (hold) begin
      @(negedge clk);
      check_val("hold_we", {31'd0, op_we}, 32'd0);
    end
    drop_valid();
    @(negedge clk);
    check_val("post_we", {30'd0, op_we, pcpi_ready}, 32'd0);
    finish_cmd();
  endtask

  task automatic do_start(input int drop_at);
    if (drop_at == 0) sb.push_back(32'd7);
    issue(mk(3'b111, 5'd0, 16'd0));
    for (int k = 1; k <= 9; k++) begin
      if (k == drop_at) drop_valid();
      @(negedge clk);
      if (k <= 7)
        check_val("run", run_word(arr_en, arr_first, pcpi_wait, res_capture, arr_step),
                  run_word(1'b1, k == 1, 1'b1, 1'b0, 3'(k - 1)));
      else
        check_val("latch_resp", run_word(arr_en, arr_first, pcpi_wait, res_capture, arr_step),
                  run_word(1'b0, 1'b0, k == 8, k == 8, 3'd0));
    end
    check_val("start_ready", {31'd0, pcpi_ready}, {31'd0, drop_at == 0});
    if (drop_at == 0) drop_valid();
    finish_cmd();
  endtask

  task automatic do_read(input logic [4:0] a);
    sb.push_back(read_model(a));
    issue(mk(3'b010, a, 16'd0));
    @(negedge clk);
    check_val("rd_addr", {28'd0, res_rd_addr}, {28'd0, a[3:0]});
    check_val("rd_early", {31'd0, pcpi_ready}, 32'd0);
    @(negedge clk);
    check_val("rd_ready", {31'd0, pcpi_ready}, 32'd1);
    drop_valid();
    finish_cmd();
  endtask

  task automatic do_unclaimed(input logic [31:0] insn);
    issue(insn);
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      check_val("unclaimed", {27'd0, pcpi_ready, pcpi_wait, pcpi_wr, op_we, arr_en}, 32'd0);
    end
    drop_valid();
    @(negedge clk);
  endtask

  initial begin
    for (int i = 0; i < 16; i++) bank[i] = 32'(i * 1000 - 5000);
    bank[4] = -32'sd80;

    repeat (3) @(negedge clk);
    check_val("rst_ctl", {20'd0, pcpi_wr, pcpi_wait, pcpi_ready, op_we, arr_en, arr_first,
                          res_capture, arr_step, 1'b0},
              32'd0);
    check_val("rst_rd", pcpi_rd, 32'd0);
    check_val("rst_addr", {23'd0, res_rd_addr, op_addr}, 32'd0);
    check_val("rst_wdata", {16'd0, op_wdata}, 32'd0);
    @(posedge clk); #1;
    resetn = 1'b1;
    mon_en = 1'b1;

    do_imm(3'b000, 5'd10, 16'h0005, 1'b0);
    do_imm(3'b000, 5'd26, 16'hBEEF, 1'b0);
    do_imm(3'b000, 5'd27, 16'h1234, 1'b0);
    do_imm(3'b000, 5'd3,  16'hA5A5, 1'b1);
    do_imm(3'b101, 5'd2,  16'h00FF, 1'b0);

    do_start(0);
    do_start(3);

    do_read(5'd4);
    do_read(5'd0);
    do_read(5'd8);
    do_read(5'd12);
    do_read(5'd20);
`ifdef MATMUL_THRESHOLD_EN
    do_imm(3'b001, 5'd0, 16'hFF9C, 1'b0);
    thr_m = -32'sd100;
    do_read(5'd4);
    do_read(5'd0);
`endif

    do_unclaimed(32'h0000_0033);
    do_unclaimed(mk(3'b011, 5'd4, 16'd1));
`ifndef MATMUL_THRESHOLD_EN
    do_unclaimed(mk(3'b001, 5'd4, 16'd1));
`endif

    // Reset asserted during cycle T+4 of a START.
    issue(mk(3'b111, 5'd0, 16'd0));
    repeat (3) @(negedge clk);
    @(posedge clk); #1;
    resetn = 1'b0;
    @(negedge clk);
    @(posedge clk); #1;
    resetn     = 1'b1;
    pcpi_valid = 1'b0;
    @(negedge clk);
    check_val("rst_run", run_word(arr_en, arr_first, pcpi_wait, res_capture, arr_step),
              run_word(1'b0, 1'b0, 1'b0, 1'b0, 3'd0));
    check_val("rst_ready", {31'd0, pcpi_ready}, 32'd0);
    repeat (12) @(negedge clk);
    do_imm(3'b000, 5'd9, 16'h0042, 1'b0);
    do_start(0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, miscompares=%0d", miscompares);
    $fatal(1, "timeout");
  end

endmodule
